video_timing_gen: RTL
=====================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter ACTIVE_H, default 1280, active pixels per line.
REQ-002 Parameter H_FP, default 110, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 40, horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 220, horizontal back porch in pixels; TOTAL_H = sum of the four = 1650.
REQ-005 Parameter ACTIVE_V, default 720, active lines per frame.
REQ-006 Parameter V_FP, default 5, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 5, vertical sync width in lines.
REQ-008 Parameter V_BP, default 20, vertical back porch in lines; TOTAL_V = sum of the four = 750.
REQ-009 Parameter FC_WIDTH, default 6, frame counter width.
REQ-010 clk  input  1  single clock, all logic on rising edge.
REQ-011 rst  input  1  asynchronous, active-low reset.
REQ-012 enable  input  1  pixel strobe; timing advances only on cycles with enable=1.
REQ-013 h_count_out  output  11  current horizontal position, 0..TOTAL_H-1.
REQ-014 v_count_out  output  10  current line, 0..TOTAL_V-1.
REQ-015 active_draw_out  output  1  high when h_count_out<ACTIVE_H and v_count_out<ACTIVE_V.
REQ-016 hsync_out  output  1  active-high horizontal sync.
REQ-017 vsync_out  output  1  active-high vertical sync.
REQ-018 new_frame_out  output  1  one-cycle pulse at start of vertical blanking.
REQ-019 frame_count_out  output  FC_WIDTH  completed-frame counter.

Function
REQ-020 All outputs are registered; decoded outputs (active_draw, hsync, vsync, new_frame) are computed from next-state counts so they are aligned with h_count_out/v_count_out in the same cycle.
REQ-021 On an enable=1 cycle, h advances by 1; at h=TOTAL_H-1 it wraps to 0 and v advances by 1; at v=TOTAL_V-1 with h wrap, v wraps to 0.
REQ-022 On an enable=0 cycle, h, v, active_draw, hsync, vsync, frame_count hold; new_frame_out is 0.
REQ-023 hsync_out=1 iff ACTIVE_H+H_FP <= h_count_out < ACTIVE_H+H_FP+H_SYNC (defaults 1390..1429).
REQ-024 vsync_out=1 iff ACTIVE_V+V_FP <= v_count_out < ACTIVE_V+V_FP+V_SYNC (defaults 725..729), for all h in those lines.
REQ-025 new_frame_out=1 for exactly one cycle: the enabled advance that lands on h=ACTIVE_H, v=ACTIVE_V (1280,720); this is the point downstream blocks use for per-frame updates.
REQ-026 frame_count_out increments by 1 in the same cycle new_frame_out asserts; wraps from 2^FC_WIDTH-1 to 0.
REQ-027 The h/v state is a two-counter machine with no other states; no illegal-count recovery beyond reset is required, but counts never exceed TOTAL-1 in normal operation.
REQ-028 Counters sized 11/10 bits; TOTAL_H<=2048 and TOTAL_V<=1024 are required parameter constraints.

Reset
REQ-029 While rst=0: h_count_out=TOTAL_H-1 (1649), v_count_out=TOTAL_V-1 (749), active_draw_out=0, hsync_out=0, vsync_out=0, new_frame_out=0, frame_count_out=0.
REQ-030 Reset takes effect immediately on rst falling, independent of clk, including mid-line or mid-frame.
REQ-031 First enabled cycle after reset release produces h=0, v=0, active_draw_out=1.

Verification
REQ-032 Reset release, enable held 1 -> cycle 1: (0,0), active=1; cycle 1280 of line: h=1279 last active; h=1280 active=0.
REQ-033 Run one full line -> hsync_out high exactly 40 cycles at h=1390..1429; h wraps 1649->0 with v 0->1.
REQ-034 Run two full frames (2*1,237,500 enabled cycles) -> vsync high on lines 725..729 only; new_frame pulses twice, each at (1280,720); frame_count 0->1->2.
REQ-035 Toggle enable 50% random -> counts advance only on enable=1; new_frame never asserted on enable=0 cycle; total frame length in enabled cycles still 1,237,500.
REQ-036 Preload frame_count to 63 (run 63 frames or use FC_WIDTH=2 with 3 frames) -> next new_frame wraps frame_count to 0.
REQ-037 Assert rst mid-frame at (500,300) asynchronously -> outputs go to reset values without waiting for clk; after release next enabled cycle gives (0,0).

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running h/v counters advanced by a pixel strobe,
// with registered blanking/sync/frame-start decodes aligned to the counts.
module video_timing_gen #(
  parameter int ACTIVE_H = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int ACTIVE_V = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int FC_WIDTH = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  output logic [10:0]         h_count_out,
  output logic [9:0]          v_count_out,
  output logic                active_draw_out,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic                new_frame_out,
  output logic [FC_WIDTH-1:0] frame_count_out
);

  localparam int TOTAL_H = ACTIVE_H + H_FP + H_SYNC + H_BP;
  localparam int TOTAL_V = ACTIVE_V + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(TOTAL_H - 1);
  localparam logic [10:0] H_ACT    = 11'(ACTIVE_H);
  localparam logic [10:0] HS_START = 11'(ACTIVE_H + H_FP);
  localparam logic [10:0] HS_END   = 11'(ACTIVE_H + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST   = 10'(TOTAL_V - 1);
  localparam logic [9:0]  V_ACT    = 10'(ACTIVE_V);
  localparam logic [9:0]  VS_START = 10'(ACTIVE_V + V_FP);
  localparam logic [9:0]  VS_END   = 10'(ACTIVE_V + V_FP + V_SYNC);

  logic [10:0]         h_q, h_d;
  logic [9:0]          v_q, v_d;
  logic                active_q, active_d;
  logic                hsync_q, hsync_d;
  logic                vsync_q, vsync_d;
  logic                new_frame_q, new_frame_d;
  logic [FC_WIDTH-1:0] fc_q, fc_d;

  // Decodes use the next-state counts so each registered flag lines up with
  // the count it describes rather than lagging it by one strobe.
  always_comb begin
    h_d         = h_q;
    v_d         = v_q;
    new_frame_d = 1'b0;
    fc_d        = fc_q;
    if (enable) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 11'd1;
      end
      if ((h_d == H_ACT) && (v_d == V_ACT)) begin
        new_frame_d = 1'b1;
        fc_d        = fc_q + FC_WIDTH'(1);
      end
    end
    active_d = (h_d < H_ACT) && (v_d < V_ACT);
    hsync_d  = (h_d >= HS_START) && (h_d < HS_END);
    vsync_d  = (v_d >= VS_START) && (v_d < VS_END);
  end

  // Reset parks the counters on the last pixel so the first strobe lands on (0,0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q         <= H_LAST;
      v_q         <= V_LAST;
      active_q    <= 1'b0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      new_frame_q <= 1'b0;
      fc_q        <= '0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      active_q    <= active_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      new_frame_q <= new_frame_d;
      fc_q        <= fc_d;
    end
  end

  assign h_count_out     = h_q;
  assign v_count_out     = v_q;
  assign active_draw_out = active_q;
  assign hsync_out       = hsync_q;
  assign vsync_out       = vsync_q;
  assign new_frame_out   = new_frame_q;
  assign frame_count_out = fc_q;

endmodule
